vga_scanout: RTL

Display-side reader for the GPU frame buffer. The CPU side writes 8-bit RGB332 pixels into VRAM through the MMIO address/data registers; this block is the matching reader. It walks VRAM in raster order at the VGA 640x480@60 pixel rate, scaling each 160x120 VRAM pixel to a 4x4 screen block. It drives the board's VGA pins and raises a one-cycle vertical-blank strobe that software can use for tear-free updates.

---
 rtl/vga_pkg.sv | 48 ++++
 rtl/vga_timing.sv | 59 +++++
 rtl/vga_scanout.sv | 106 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and pixel types for the frame-buffer scanout.
// VRAM holds 160x120 RGB332 pixels, each shown as a 4x4 block on screen.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int VRAM_W = 160;
    localparam int VRAM_H = 120;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Widen each channel by repeating its top bits so full scale maps to 4'hF.
    function automatic rgb444_t expand_rgb332(input rgb332_t px);
        rgb444_t c;
        c.r = {px.r, px.r[2]};
        c.g = {px.g, px.g[2]};
        c.b = {px.b, px.b};
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider and raster counters for 640x480@60; produces raw (undelayed)
// sync, active-video and the vertical-blank strobe.
module vga_timing
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic             pe,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             active_raw,
    output logic             vblank
);

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

    // pe is low out of reset, so the first counting edge is the second clk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe <= 1'b0;
        end else begin
            pe <= ~pe;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pe) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // High for one clk right after the edge that moves the raster onto line 480.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank <= 1'b0;
        end else begin
            vblank <= pe && h_last && (v_cnt == CNT_W'(V_VISIBLE - 1));
        end
    end

    assign hsync_raw  = !((h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt < CNT_W'(H_SYNC_END)));
    assign vsync_raw  = !((v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt < CNT_W'(V_SYNC_END)));
    assign active_raw = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));

endmodule

// File: rtl/vga_scanout.sv
// Frame-buffer reader: walks VRAM in raster order, decodes RGB332 and drives the VGA pins
// with sync delayed to line up exactly with the colour path.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_SCALE_LOG2 = 2,
    parameter int V_SCALE_LOG2 = 2,
    parameter int ADDR_W       = 15
) (
    input  logic              clk,
    input  logic              RST_N,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic              vram_re_o,
    input  logic [7:0]        vram_data_i,
    output logic              Hsync,
    output logic              Vsync,
    output logic [3:0]        vgaRed,
    output logic [3:0]        vgaGreen,
    output logic [3:0]        vgaBlue,
    output logic              vblank_o
);

    localparam int LAST_ADDR = VRAM_W * VRAM_H - 1;

    logic             pe;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             active_raw;

    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] addr_next;

    logic    active_d1;
    logic    hsync_d1;
    logic    vsync_d1;
    rgb444_t colour;

    vga_timing u_timing (
        .clk        (clk),
        .rst_n      (RST_N),
        .pe         (pe),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .hsync_raw  (hsync_raw),
        .vsync_raw  (vsync_raw),
        .active_raw (active_raw),
        .vblank     (vblank_o)
    );

    // row*160 built from two shifts; outside active video the address parks at 0.
    assign row       = ADDR_W'(v_cnt >> V_SCALE_LOG2);
    assign col       = ADDR_W'(h_cnt >> H_SCALE_LOG2);
    assign addr_next = (row << 7) + (row << 5) + col;

    assign colour = expand_rgb332(rgb332_t'(vram_data_i));

    // S1: issue the read and carry sync/active alongside it.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            vram_addr_o <= '0;
            vram_re_o   <= 1'b0;
            active_d1   <= 1'b0;
            hsync_d1    <= 1'b1;
            vsync_d1    <= 1'b1;
        end else if (pe) begin
            if (!active_raw) begin
                vram_addr_o <= '0;
            end else if (addr_next > ADDR_W'(LAST_ADDR)) begin
                vram_addr_o <= ADDR_W'(LAST_ADDR);
            end else begin
                vram_addr_o <= addr_next;
            end
            vram_re_o <= active_raw;
            active_d1 <= active_raw;
            hsync_d1  <= hsync_raw;
            vsync_d1  <= vsync_raw;
        end
    end

    // S2: read data arrived one clk after S1, so it is stable on the next pe.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            Hsync    <= 1'b1;
            Vsync    <= 1'b1;
            vgaRed   <= 4'h0;
            vgaGreen <= 4'h0;
            vgaBlue  <= 4'h0;
        end else if (pe) begin
            Hsync <= hsync_d1;
            Vsync <= vsync_d1;
            if (active_d1) begin
                vgaRed   <= colour.r;
                vgaGreen <= colour.g;
                vgaBlue  <= colour.b;
            end else begin
                vgaRed   <= 4'h0;
                vgaGreen <= 4'h0;
                vgaBlue  <= 4'h0;
            end
        end
    end

endmodule
